// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
//   Shared definitions for the iterative RV32M multiply/divide unit:
//   operand width, iteration counter width, funct3 operation codes, FSM state
//   encodings and small decode helpers used by muldiv_unit.
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    // Operand/result width; the unit performs exactly MD_N iterations.
    localparam int MD_N  = 32;
    localparam int MD_CW = $clog2(MD_N);

    // funct3 encodings of the M extension.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic op_is_rem(input md_op_e op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    // rs1 is treated as signed by everything except MULHU and the unsigned divides.
    function automatic logic a_is_signed(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    // rs2 is signed only for MUL/MULH and the signed divides (MULHSU treats it unsigned).
    function automatic logic b_is_signed(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage : muldiv_unit_pkg

// File: rtl/muldiv_unit_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_unit_signfix
//   Combinational conditional two's-complement negation. Used on the inputs to
//   turn signed operands into magnitudes, and on the raw product / quotient /
//   remainder to restore the sign of the final result.
//
//   Ports:
//     val_i  [W-1:0]  value to condition
//     neg_i           1 = negate, 0 = pass through
//     val_o  [W-1:0]  neg_i ? -val_i : val_i
// -----------------------------------------------------------------------------
module muldiv_unit_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule : muldiv_unit_signfix

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit sitting beside the ALU in EX.
//   A request accepted in IDLE runs MD_N shift-add (multiply) or restoring
//   (divide) iterations on operand magnitudes, then spends one FIN cycle with
//   done high and the sign-corrected result on the output. Latency is a fixed
//   MD_N+1 cycles for every op, special cases included.
//
//   Ports:
//     clk     rising-edge clock
//     rst     asynchronous, active-high reset
//     start   request, sampled only in IDLE
//     kill    flush; aborts any operation, no done pulse, result untouched
//     op      funct3 operation code (md_op_e)
//     a, b    rs1 / rs2 operands, latched when start is accepted
//     busy    high whenever the FSM is not IDLE
//     done    one-cycle pulse in FIN, when result is valid
//     result  final value; holds until the next operation completes or rst
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [MD_N-1:0] a,
    input  logic [MD_N-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [MD_N-1:0] result
);

    localparam int N = MD_N;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    md_state_e          state_q;
    md_op_e             op_q;
    logic [MD_CW-1:0]   count_q;
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [2*N-1:0]     acc_q;
    logic [2*N-1:0]     acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [N-1:0]       opnd_q;
    logic [N-1:0]       a_q;       // original rs1, returned by REM/REMU on b=0
    logic               sa_q;      // rs1 was negative and treated as signed
    logic               sb_q;      // rs2 was negative and treated as signed
    logic               bzero_q;
    logic               done_q;
    logic [N-1:0]       result_q;

    // ------------------------------------------------------------------
    // Operand conditioning at acceptance
    // ------------------------------------------------------------------
    md_op_e       op_in;
    logic         neg_a_in;
    logic         neg_b_in;
    logic [N-1:0] mag_a;
    logic [N-1:0] mag_b;

    assign op_in    = md_op_e'(op);
    assign neg_a_in = a[N-1] & a_is_signed(op_in);
    assign neg_b_in = b[N-1] & b_is_signed(op_in);

    muldiv_unit_signfix #(.W(N)) u_fix_a (
        .val_i (a),
        .neg_i (neg_a_in),
        .val_o (mag_a)
    );

    muldiv_unit_signfix #(.W(N)) u_fix_b (
        .val_i (b),
        .neg_i (neg_b_in),
        .val_o (mag_b)
    );

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [N:0] mul_sum;
    logic [N:0] div_shift;
    logic [N:0] div_diff;

    // NOTE: every signal written in an always_comb gets a default first,
    // otherwise a missed branch infers a latch.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
        div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole register right.
        acc_d     = {mul_sum, acc_q[N-1:1]};
        if (op_is_div(op_q)) begin
            // Restoring step: the top bit of the N+1 bit difference is the
            // borrow, i.e. the divisor did not fit.
            if (!div_diff[N]) begin
                acc_d = {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
            end else begin
                acc_d = {div_shift[N-1:0], acc_q[N-2:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Final sign correction and special cases. Evaluated on the value the
    // last iteration produces so result and done are registered on entry
    // to FIN and are valid throughout the FIN cycle.
    // ------------------------------------------------------------------
    logic [2*N-1:0] fix_in;
    logic           fix_neg;
    logic [2*N-1:0] fix_out;
    logic [N-1:0]   final_result;

    always_comb begin
        fix_in  = acc_d;
        fix_neg = sa_q ^ sb_q;
        if (op_is_rem(op_q)) begin
            // Remainder follows the dividend's sign.
            fix_in  = {{N{1'b0}}, acc_d[2*N-1:N]};
            fix_neg = sa_q;
        end else if (op_is_div(op_q)) begin
            fix_in  = {{N{1'b0}}, acc_d[N-1:0]};
        end
    end

    muldiv_unit_signfix #(.W(2*N)) u_fix_res (
        .val_i (fix_in),
        .neg_i (fix_neg),
        .val_o (fix_out)
    );

    // The signed overflow case (-2^(N-1) / -1) needs no special handling:
    // magnitudes give quotient 2^(N-1) with positive sign and remainder 0,
    // which is exactly the architected answer.
    always_comb begin
        final_result = fix_out[N-1:0];
        unique case (op_q)
            MD_MUL:                       final_result = fix_out[N-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_result = fix_out[2*N-1:N];
            MD_DIV, MD_DIVU:              final_result = bzero_q ? {N{1'b1}} : fix_out[N-1:0];
            MD_REM, MD_REMU:              final_result = bzero_q ? a_q : fix_out[N-1:0];
            default:                      final_result = fix_out[N-1:0];
        endcase
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of every other register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset too; the unit is small and a
        // defined post-reset state keeps result and the accumulators clean.
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_MUL;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bzero_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !kill) begin
                        state_q <= ST_RUN;
                        op_q    <= op_in;
                        count_q <= '0;
                        a_q     <= a;
                        sa_q    <= neg_a_in;
                        sb_q    <= neg_b_in;
                        bzero_q <= (b == '0);
                        if (op_is_div(op_in)) begin
                            opnd_q <= mag_b;
                            acc_q  <= {{N{1'b0}}, mag_a};
                        end else begin
                            opnd_q <= mag_a;
                            acc_q  <= {{N{1'b0}}, mag_b};
                        end
                    end
                end
                ST_RUN: begin
                    if (kill) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q   <= acc_d;
                        count_q <= count_q + MD_CW'(1);
                        if (count_q == MD_CW'(N - 1)) begin
                            state_q  <= ST_FIN;
                            result_q <= final_result;
                            done_q   <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed self-checking bench for muldiv_unit. Each test task drives one
//   scenario and compares DUT outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int N   = 32;
    localparam int LAT = N + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic          clk;
    logic          rst;
    logic          start;
    logic          kill;
    logic [2:0]    op;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;

    int tests_run = 0;
    int tests_failed = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation. Caller must be 1 time unit after a rising edge.
    // Operands are scrambled right after acceptance. If poke > 0, a stray
    // start is driven during that cycle of the run. Returns the cycle at
    // which done was seen (0 on timeout), the number of busy cycles, and the
    // busy/done levels one cycle after done. Leaves the bench 1 unit after
    // the edge that ends the FIN cycle.
    task automatic run_op(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                          input int poke, output logic [N-1:0] res, output int lat,
                          output int busy_cnt, output logic busy_after, output logic done_after);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 3'($urandom);
        lat      = 0;
        busy_cnt = 0;
        res      = '0;
        for (int k = 1; k <= 100; k++) begin
            start = (k == poke);
            if (k == poke) begin
                op = OP_MUL;
                a  = 32'd3;
                b  = 32'd3;
            end
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        busy_after = busy;
        done_after = done;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        tests_run++;
        if (result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h expected 00000000", result);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [N-1:0] res;
        int lat, bc;
        logic ba, da;
        run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 0, res, lat, bc, ba, da);
        tests_run++;
        if (res !== 32'hFFFFFFEB) begin
            tests_failed++;
            $display("FAIL mul_7x-3: got %h expected FFFFFFEB", res);
        end
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL mul_latency: got %0d expected %0d", lat, LAT);
        end
        tests_run++;
        if (bc !== LAT) begin
            tests_failed++;
            $display("FAIL mul_busy_cycles: got %0d expected %0d", bc, LAT);
        end
        tests_run++;
        if (ba !== 1'b0 || da !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_after_fin: got busy=%b done=%b expected 0 0", ba, da);
        end
        run_op(OP_MUL, 32'h12345678, 32'h00000010, 0, res, lat, bc, ba, da);
        tests_run++;
        if (res !== 32'h23456780) begin
            tests_failed++;
            $display("FAIL mul_low_trunc: got %h expected 23456780", res);
        end
    endtask

    task automatic test_mul_high();
        logic [2:0]   ops [4]  = '{OP_MULH, OP_MULHSU, OP_MULHU, OP_MULHU};
        logic [N-1:0] va  [4]  = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        logic [N-1:0] vb  [4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [N-1:0] exp [4]  = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
        logic [N-1:0] res;
        int lat, bc;
        logic ba, da;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], va[i], vb[i], 0, res, lat, bc, ba, da);
            tests_run++;
            if (res !== exp[i] || lat !== LAT) begin
                tests_failed++;
                $display("FAIL mul_high[%0d] op=%b: got %h lat=%0d expected %h lat=%0d",
                         i, ops[i], res, lat, exp[i], LAT);
            end
        end
    endtask

    task automatic test_divide();
        logic [2:0]   ops [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [N-1:0] va  [6] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100, 32'd20, 32'd20};
        logic [N-1:0] vb  [6] = '{32'd3, 32'd3, 32'd7, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD};
        logic [N-1:0] exp [6] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'd2, 32'hFFFFFFFA, 32'd2};
        logic [N-1:0] res;
        int lat, bc;
        logic ba, da;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], va[i], vb[i], 0, res, lat, bc, ba, da);
            tests_run++;
            if (res !== exp[i] || lat !== LAT) begin
                tests_failed++;
                $display("FAIL divide[%0d] op=%b: got %h lat=%0d expected %h lat=%0d",
                         i, ops[i], res, lat, exp[i], LAT);
            end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]   ops [6] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REMU};
        logic [N-1:0] va  [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'h80000000};
        logic [N-1:0] vb  [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [N-1:0] exp [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h80000000};
        logic [N-1:0] res;
        int lat, bc;
        logic ba, da;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], va[i], vb[i], 0, res, lat, bc, ba, da);
            tests_run++;
            if (res !== exp[i] || lat !== LAT || bc !== LAT) begin
                tests_failed++;
                $display("FAIL div_special[%0d] op=%b: got %h lat=%0d busy=%0d expected %h lat=%0d busy=%0d",
                         i, ops[i], res, lat, bc, exp[i], LAT, LAT);
            end
        end
    endtask

    task automatic test_kill();
        logic [N-1:0] res;
        int lat, bc, pulses;
        logic ba, da;
        run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 0, res, lat, bc, ba, da);
        // Start a divide, then assert kill so it is sampled at start+10.
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL kill_busy_before: got %b expected 1", busy);
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_busy_after: got %b expected 0", busy);
        end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL kill_no_done: got %0d pulses expected 0", pulses);
        end
        tests_run++;
        if (result !== 32'hFFFFFFEB) begin
            tests_failed++;
            $display("FAIL kill_result_hold: got %h expected FFFFFFEB", result);
        end
        // kill together with start in IDLE must not start anything.
        start = 1'b1;
        kill  = 1'b1;
        op    = OP_MUL;
        a     = 32'd2;
        b     = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        kill  = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_with_start: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_start_while_busy();
        logic [N-1:0] res;
        int lat, bc;
        logic ba, da;
        run_op(OP_DIVU, 32'd100, 32'd7, 5, res, lat, bc, ba, da);
        tests_run++;
        if (res !== 32'd14 || lat !== LAT) begin
            tests_failed++;
            $display("FAIL busy_start_result: got %h lat=%0d expected 0000000e lat=%0d", res, lat, LAT);
        end
        tests_run++;
        if (ba !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_start_ignored: got busy=%b after FIN expected 0", ba);
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] res;
        int lat, bc;
        logic ba, da;
        // Result currently holds 14 from the previous test.
        start = 1'b1;
        op    = OP_MUL;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h expected 0 0 00000000",
                     busy, done, result);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(OP_DIVU, 32'd100, 32'd7, 0, res, lat, bc, ba, da);
        tests_run++;
        if (res !== 32'd14 || lat !== LAT) begin
            tests_failed++;
            $display("FAIL post_reset_op: got %h lat=%0d expected 0000000e lat=%0d", res, lat, LAT);
        end
    endtask

    // Two ops issued with the minimum single IDLE cycle between them.
    task automatic test_back_to_back();
        logic [N-1:0] r1, r2;
        int l1, l2, bc;
        logic ba, da;
        run_op(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, r1, l1, bc, ba, da);
        run_op(OP_REM, 32'hFFFFFFF9, 32'd2, 0, r2, l2, bc, ba, da);
        tests_run++;
        if (r1 !== 32'd1 || l1 !== LAT) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h lat=%0d expected 00000001 lat=%0d", r1, l1, LAT);
        end
        tests_run++;
        if (r2 !== 32'hFFFFFFFF || l2 !== LAT) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h lat=%0d expected ffffffff lat=%0d", r2, l2, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_divide();
        test_div_special();
        test_kill();
        test_start_while_busy();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_muldiv_unit
